// File: rtl/count_pkg.sv
// Shared definitions for the mod-N up/down counter: direction encoding and
// prescaler register sizing.
package count_pkg;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Prescaler counter width: clog2(PRESCALE), never less than one bit.
  function automatic int prescale_width(input int prescale);
    return (prescale <= 2) ? 1 : $clog2(prescale);
  endfunction

endpackage

// File: rtl/count_modn_updn_if.sv
// Control/status bundle of count_modn_updn. SAT exists only when COUNT_SAT_EN
// is defined.
interface count_modn_updn_if #(
  parameter int WIDTH = 8
);
  logic             EN;
  logic             DIR;
  logic             LOAD;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] MAX;
`ifdef COUNT_SAT_EN
  logic             SAT;
`endif
  logic [WIDTH-1:0] Q;
  logic             TC;

`ifdef COUNT_SAT_EN
  modport master (output EN, DIR, LOAD, D, MAX, SAT, input Q, TC);
  modport slave  (input EN, DIR, LOAD, D, MAX, SAT, output Q, TC);
`else
  modport master (output EN, DIR, LOAD, D, MAX, input Q, TC);
  modport slave  (input EN, DIR, LOAD, D, MAX, output Q, TC);
`endif

endinterface

// File: rtl/count_modn_updn_tick_gen.sv
// tick_gen: counts enabled clocks 0..PRESCALE-1 and flags the last one as TICK.
// CLR restarts the period; EN low freezes it.
module tick_gen
  import count_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic CLK,
  input  logic RST,
  input  logic EN,
  input  logic CLR,
  output logic TICK
);

  localparam int            PW   = prescale_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  assign TICK = EN & ~CLR & (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt <= '0;
    end else if (CLR) begin
      cnt <= '0;
    end else if (EN) begin
      cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/count_modn_updn.sv
// Mod-(MAX+1) up/down counter with synchronous load, enable prescaler and a
// registered terminal-count pulse. Define COUNT_SAT_EN to add saturating mode.
module count_modn_updn
  import count_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 1
) (
  input logic               CLK,
  input logic               RST,
  count_modn_updn_if.slave  bus
);

  logic             tick;
  logic             step;
  dir_e             dir;
  logic [WIDTH-1:0] q, q_nxt;
  logic             tc, tc_nxt;
  logic [WIDTH-1:0] wrap_up, wrap_dn;

  tick_gen #(.PRESCALE(PRESCALE)) u_tick_gen (
    .CLK  (CLK),
    .RST  (RST),
    .EN   (bus.EN),
    .CLR  (bus.LOAD),
    .TICK (tick)
  );

  assign step = tick & ~bus.LOAD;
  assign dir  = dir_e'(bus.DIR);

  // Value taken when a step runs off either end of 0..MAX.
`ifdef COUNT_SAT_EN
  assign wrap_up = bus.SAT ? bus.MAX : '0;
  assign wrap_dn = bus.SAT ? '0 : bus.MAX;
`else
  assign wrap_up = '0;
  assign wrap_dn = bus.MAX;
`endif

  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    q_nxt  = q;
    tc_nxt = 1'b0;
    if (bus.LOAD) begin
      q_nxt = (bus.D <= bus.MAX) ? bus.D : bus.MAX;
    end else if (step) begin
      unique case (dir)
        DIR_UP: begin
          if (q < bus.MAX) begin
            q_nxt = q + 1'b1;
          end else begin
            q_nxt  = wrap_up;
            tc_nxt = 1'b1;
          end
        end
        DIR_DOWN: begin
          // Above a lowered MAX, fall back into range without flagging TC.
          if (q > bus.MAX) begin
            q_nxt = bus.MAX;
          end else if (q != '0) begin
            q_nxt = q - 1'b1;
          end else begin
            q_nxt  = wrap_dn;
            tc_nxt = 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      q  <= '0;
      tc <= 1'b0;
    end else begin
      q  <= q_nxt;
      tc <= tc_nxt;
    end
  end

  assign bus.Q  = q;
  assign bus.TC = tc;

endmodule

// File: tb/tb_count_modn_updn.sv
// Bench for count_modn_updn: PRESCALE=1 and PRESCALE=4 instances share one
// stimulus stream and are compared every cycle against a behavioural model.
module tb_count_modn_updn;
  import count_pkg::*;

  localparam int WIDTH = 8;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic             en, dir, load, sat;
  logic [WIDTH-1:0] d, maxv;

  count_modn_updn_if #(.WIDTH(WIDTH)) bus1 ();
  count_modn_updn_if #(.WIDTH(WIDTH)) bus4 ();

  assign bus1.EN = en;   assign bus4.EN = en;
  assign bus1.DIR = dir; assign bus4.DIR = dir;
  assign bus1.LOAD = load; assign bus4.LOAD = load;
  assign bus1.D = d;     assign bus4.D = d;
  assign bus1.MAX = maxv; assign bus4.MAX = maxv;
`ifdef COUNT_SAT_EN
  assign bus1.SAT = sat; assign bus4.SAT = sat;
`endif

  count_modn_updn #(.WIDTH(WIDTH), .PRESCALE(1)) dut1 (
    .CLK (CLK), .RST (RST), .bus (bus1.slave));
  count_modn_updn #(.WIDTH(WIDTH), .PRESCALE(4)) dut4 (
    .CLK (CLK), .RST (RST), .bus (bus4.slave));

  int vectors = 0;
  int miscompares = 0;

  // Reference model: index 0 is the PRESCALE=1 instance, index 1 PRESCALE=4.
  int presc[2] = '{1, 4};
  int mq[2];
  int mtc[2];
  int mps[2];

  function automatic bit sat_active();
`ifdef COUNT_SAT_EN
    return sat;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mq[k] = 0; mtc[k] = 0; mps[k] = 0;
    end
  endtask

  // Applies the counter rules for one rising edge with the current inputs.
  task automatic model_clock();
    int  top;
    bit  stp;
    top = int'(maxv);
    for (int k = 0; k < 2; k++) begin
      mtc[k] = 0;
      if (load) begin
        mq[k]  = (int'(d) <= top) ? int'(d) : top;
        mps[k] = 0;
      end else begin
        stp = en && (mps[k] == presc[k] - 1);
        if (en) mps[k] = (mps[k] + 1) % presc[k];
        if (stp) begin
          if (dir == 1'b0) begin
            if (mq[k] < top) mq[k] = mq[k] + 1;
            else begin mq[k] = sat_active() ? top : 0; mtc[k] = 1; end
          end else begin
            if (mq[k] > top) mq[k] = top;
            else if (mq[k] > 0) mq[k] = mq[k] - 1;
            else begin mq[k] = sat_active() ? 0 : top; mtc[k] = 1; end
          end
        end
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    check("q_p1",  32'(bus1.Q),  32'(mq[0]));
    check("tc_p1", 32'(bus1.TC), 32'(mtc[0]));
    check("q_p4",  32'(bus4.Q),  32'(mq[1]));
    check("tc_p4", 32'(bus4.TC), 32'(mtc[1]));
  endtask

  // One clock: model first with the inputs about to be sampled, then compare.
  task automatic cycle();
    model_clock();
    @(posedge CLK);
    #1;
    check_model();
  endtask

  // Reset pulse placed between clock edges; outputs must clear without a clock.
  task automatic pulse_reset();
    #1 RST = 1'b1;
    #1;
    model_reset();
    check("rst_q_p1",  32'(bus1.Q),  32'd0);
    check("rst_tc_p1", 32'(bus1.TC), 32'd0);
    check("rst_q_p4",  32'(bus4.Q),  32'd0);
    #1 RST = 1'b0;
  endtask

  initial begin
    en = 1'b0; dir = 1'b0; load = 1'b0; sat = 1'b0; d = '0; maxv = 8'd49;
    model_reset();

    // Reset state with RST held high across edges.
    #1;
    check("por_q_p1", 32'(bus1.Q), 32'd0);
    @(posedge CLK); #1;
    check_model();
    @(negedge CLK);
    RST = 1'b0;

    // Count up 0..49 then wrap to 0 with a single-cycle TC.
    en = 1'b1;
    for (int i = 1; i <= 49; i++) begin
      cycle();
      check("up_q", 32'(bus1.Q), 32'(i));
    end
    cycle();
    check("up_wrap_q",  32'(bus1.Q),  32'd0);
    check("up_wrap_tc", 32'(bus1.TC), 32'd1);
    cycle();
    check("up_after_tc", 32'(bus1.TC), 32'd0);

    // Down from 0 wraps to MAX, then counts down normally.
    load = 1'b1; d = 8'd0;
    cycle();
    load = 1'b0; dir = 1'b1;
    cycle();
    check("dn_wrap_q",  32'(bus1.Q),  32'd49);
    check("dn_wrap_tc", 32'(bus1.TC), 32'd1);
    cycle();
    check("dn_q",  32'(bus1.Q),  32'd48);
    check("dn_tc", 32'(bus1.TC), 32'd0);

    // Load clamps to MAX; load beats an enabled step.
    load = 1'b1; d = 8'd60; en = 1'b0;
    cycle();
    check("ld_clamp", 32'(bus1.Q), 32'd49);
    d = 8'd7; en = 1'b1;
    cycle();
    check("ld_pri_q",  32'(bus1.Q),  32'd7);
    check("ld_pri_tc", 32'(bus1.TC), 32'd0);

    // Prescale by 4 with a two-clock enable gap mid-period.
    d = 8'd0; dir = 1'b0;
    cycle();
    load = 1'b0;
    for (int i = 0; i < 3; i++) cycle();
    check("ps_hold", 32'(bus4.Q), 32'd0);
    cycle();
    check("ps_step1", 32'(bus4.Q), 32'd1);
    cycle(); cycle();
    en = 1'b0;
    cycle(); cycle();
    en = 1'b1;
    cycle();
    check("ps_delayed", 32'(bus4.Q), 32'd1);
    cycle();
    check("ps_step2", 32'(bus4.Q), 32'd2);

    // Mid-cycle reset from Q=23, then restart from 0.
    load = 1'b1; d = 8'd23; en = 1'b0;
    cycle();
    check("pre_rst_q", 32'(bus1.Q), 32'd23);
    load = 1'b1; d = 8'd40;
    pulse_reset();
    load = 1'b0; en = 1'b1;
    cycle();
    check("post_rst_q", 32'(bus1.Q), 32'd1);

`ifdef COUNT_SAT_EN
    // Saturation at the top, then a lowered MAX pulls Q down without TC.
    sat = 1'b1; load = 1'b1; d = 8'd49; maxv = 8'd49;
    cycle();
    load = 1'b0; dir = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("sat_q",  32'(bus1.Q),  32'd49);
      check("sat_tc", 32'(bus1.TC), 32'd1);
    end
    maxv = 8'd20; dir = 1'b1;
    cycle();
    check("lower_q",  32'(bus1.Q),  32'd20);
    check("lower_tc", 32'(bus1.TC), 32'd0);
    sat = 1'b0;
`endif

    // MAX = 0: every step holds 0 and flags TC.
    maxv = 8'd0; load = 1'b0; en = 1'b1; dir = 1'b0;
    cycle();
    cycle();
    check("max0_q",  32'(bus1.Q),  32'd0);
    check("max0_tc", 32'(bus1.TC), 32'd1);

    // Randomised traffic, including runtime MAX changes and stray resets.
    maxv = 8'd49;
    for (int i = 0; i < 600; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      dir  = 1'($urandom_range(0, 1));
      load = ($urandom_range(0, 15) == 0);
      d    = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0)
        maxv = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3))
                                           : 8'($urandom_range(0, 255));
`ifdef COUNT_SAT_EN
      sat = ($urandom_range(0, 3) == 0);
`endif
      if ($urandom_range(0, 63) == 0) pulse_reset();
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
